// File: rtl/axi_stream_fifo_pkg.sv
// Shared constants and helpers for the AXI-stream helper blocks.
// Provides default payload width, default depth and the level-width helper.
package axi_stream_fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter for the stream FIFO.
// Ports: clk, rst (sync high), i_clr (sync clear), i_inc (advance), o_ptr.
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    // Power-of-two depth: natural binary wrap gives modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/axi_stream_fifo.sv
// Synchronous valid/ready FIFO with registered handshake outputs.
// Ports: clk, rst, flush; s_valid/s_ready/s_data in; m_valid/m_ready/m_data out; level.
module axi_stream_fifo
    import axi_stream_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LW-1:0]     r_level;
    logic [AW-1:0]     w_wptr;
    logic [AW-1:0]     w_rptr;
    logic              w_push;
    logic              w_pop;
    logic              w_upd;

    // Handshake flags come only from registered level, so m_ready
    // never reaches s_ready combinationally.
    assign s_ready = (r_level != LW'(DEPTH));
    assign m_valid = (r_level != '0);
    assign level   = r_level;

    // Flush and reset both cancel any same-cycle transfer.
    assign w_upd  = !rst && !flush;
    assign w_push = s_valid && s_ready && w_upd;
    assign w_pop  = m_valid && m_ready && w_upd;

    fifo_ptr #(.W(AW)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_wptr)
    );

    fifo_ptr #(.W(AW)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_rptr)
    );

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_level <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign m_data = r_mem[w_rptr];

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Self-checking bench for axi_stream_fifo against a queue model.
// Directed fill/drain/stream/flush/reset phases plus random throttling.
module tb_axi_stream_fifo;

    localparam int DW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [2:0]    level;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] emitted[$];
    logic [DW-1:0] accepted[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_head  = '0;

    always #5 clk = ~clk;

    axi_stream_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, check at negedge, then advance the model at posedge.
    task automatic cyc(input logic sv, input logic [DW-1:0] sd,
                       input logic mr, input logic fl, input logic rs);
        int  n;
        logic exp_rdy, exp_vld, psh, pp;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        rst     = rs;
        @(negedge clk);
        n       = q.size();
        exp_rdy = (n < DP);
        exp_vld = (n > 0);
        check("level", 64'(level), 64'(n));
        check("s_ready", 64'(s_ready), 64'(exp_rdy));
        check("m_valid", 64'(m_valid), 64'(exp_vld));
        if (exp_vld) begin
            check("m_data", 64'(m_data), 64'(q[0]));
            if (prev_stall)
                check("stable", 64'(m_data), 64'(prev_head));
        end
        psh = sv && exp_rdy;
        pp  = exp_vld && mr;
        prev_stall = exp_vld && !mr && !fl && !rs;
        prev_head  = exp_vld ? q[0] : '0;
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (pp)
                emitted.push_back(q.pop_front());
            if (psh) begin
                q.push_back(sd);
                accepted.push_back(sd);
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0;
        s_data = '0; m_ready = 1'b0;
        q.delete();
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 1);

        // Fill to full, then offer a fifth word that must be refused.
        for (int i = 1; i <= 4; i++)
            cyc(1, DW'(i * 32'h11), 0, 0, 0);
        check("full_lvl", 64'(level), 64'(4));
        check("full_rdy", 64'(s_ready), 64'(0));
        cyc(1, 32'h55, 0, 0, 0);

        // Drain in order.
        emitted.delete();
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("drain_n", 64'(emitted.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < emitted.size())
                check("drain_d", 64'(emitted[i]), 64'((i + 1) * 32'h11));

        // Continuous streaming across several pointer wraps.
        emitted.delete();
        for (int i = 0; i < 20; i++)
            cyc(1, 32'h1000 + DW'(i), 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("strm_n", 64'(emitted.size()), 64'(20));
        for (int i = 0; i < 20; i++)
            if (i < emitted.size())
                check("strm_d", 64'(emitted[i]), 64'(32'h1000 + i));

        // Flush at level 3 with simultaneous push and pop.
        for (int i = 0; i < 3; i++)
            cyc(1, 32'hA0 + DW'(i), 0, 0, 0);
        emitted.delete();
        cyc(1, 32'hDEAD, 1, 1, 0);
        check("fl_lvl", 64'(level), 64'(0));
        check("fl_vld", 64'(m_valid), 64'(0));
        cyc(1, 32'h77, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("fl_n", 64'(emitted.size()), 64'(1));
        if (emitted.size() > 0)
            check("fl_d", 64'(emitted[0]), 64'(32'h77));

        // Reset mid-run at level 2, then a single push.
        cyc(1, 32'h01, 0, 0, 0);
        cyc(1, 32'h02, 0, 0, 0);
        cyc(1, 32'h03, 1, 0, 1);
        check("rs_lvl", 64'(level), 64'(0));
        check("rs_rdy", 64'(s_ready), 64'(1));
        check("rs_vld", 64'(m_valid), 64'(0));
        cyc(1, 32'hAB, 0, 0, 0);
        check("rs_ab", 64'(m_data), 64'(32'hAB));
        cyc(0, 0, 1, 0, 0);

        // Random throttling; ordering verified end to end.
        emitted.delete();
        accepted.delete();
        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(0, 99) < 60, $urandom,
                $urandom_range(0, 99) < 55, 0, 0);
        while (q.size() > 0 && vectors < 200000)
            cyc(0, 0, 1, 0, 0);
        check("rnd_n", 64'(emitted.size()), 64'(accepted.size()));
        begin
            int bad = 0;
            for (int i = 0; i < emitted.size() && i < accepted.size(); i++)
                if (emitted[i] !== accepted[i]) bad++;
            check("rnd_ord", 64'(bad), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_stream_fifo.md
AXI_STREAM_FIFO -- requirements
Module: axi_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of storage entries; it must be a power of two and >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream offers a word.
REQ-007 SHALL have port s_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port s_data, input, DATA_W bits: upstream payload.
REQ-009 SHALL have port m_valid, output, 1 bit: the block offers a word to downstream (the valid/ready delay/throttle stage).
REQ-010 SHALL have port m_ready, input, 1 bit: downstream accepts a word.
REQ-011 SHALL have port m_data, output, DATA_W bits: the head-of-queue payload.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-013 SHALL define push = s_valid && s_ready and pop = m_valid && m_ready, both evaluated in the same cycle.
REQ-014 SHALL drive s_ready = (level != DEPTH) and m_valid = (level != 0), decoded only from registered state, with no combinational path from m_ready to s_ready.
REQ-015 SHALL drive m_data from the entry at the read pointer; the output is undefined-but-stable while m_valid = 0.
REQ-016 SHALL present a word pushed in cycle N on m_valid/m_data in cycle N+1 at the earliest (1-cycle latency, no bypass).
REQ-017 SHALL store, on push, s_data at the write pointer and advance the write pointer by 1, modulo DEPTH.
REQ-018 SHALL advance the read pointer by 1, modulo DEPTH, on pop.
REQ-019 SHALL update level as follows: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-020 SHALL deliver words in strict arrival order, with no loss or duplication, across any number of pointer wrap-arounds.
REQ-021 SHALL hold s_ready = 0 when full (level = DEPTH), even if m_ready = 1 that cycle; simultaneous push+pop applies only when not full.
REQ-022 SHALL make pop impossible when empty (level = 0); m_ready is ignored.
REQ-023 SHALL hold m_data and m_valid stable while m_valid = 1 and m_ready = 0 (AXI-stream stability).
REQ-024 SHALL, on flush = 1, zero both pointers and level next cycle and discard any same-cycle push or pop; flush has priority over push/pop.

Reset
REQ-025 SHALL, with rst = 1 at a rising clk edge, clear the read pointer, write pointer and level to 0, giving next cycle s_ready = 1, m_valid = 0, level = 0.
REQ-026 SHALL let rst take priority over flush, push and pop, and abandon in-flight contents when rst is asserted mid-operation.
REQ-027 SHALL NOT reset the storage array contents.

Structure
REQ-028 SHALL place the level-width helper (clog2-based) and the default DATA_W/DEPTH constants in the shared package/include used by the AXI helper blocks.
REQ-029 SHALL implement storage as a single register array inside this module; no sub-module is required, and the optional pointer counter is named fifo_ptr if factored out.

Verification
REQ-030 Fill: DEPTH=4, m_ready=0, s_valid=1 with data 0x11..0x44 over 4 cycles -> level=4, s_ready=0 in the 5th cycle, and a 5th word is not accepted.
REQ-031 Drain: from full, m_ready=1 for 4 cycles -> m_data 0x11, 0x22, 0x33, 0x44 in order; then m_valid=0, level=0.
REQ-032 Streaming: s_valid=1 and m_ready=1 continuously for 20 words -> after 1 cycle of latency, one word per cycle, level held at 1, and the pointers wrap 5 times without reordering.
REQ-033 Flush: level=3, assert flush together with s_valid=1 and m_ready=1 -> next cycle level=0, m_valid=0, and the pushed word is not later emitted.
REQ-034 Reset mid-run: level=2, rst=1 for 1 cycle -> level=0, s_ready=1, m_valid=0; then push 0xAB -> m_data=0xAB one cycle later.
REQ-035 Random throttle: randomized s_valid and m_ready over 10k cycles -> the output sequence equals the input sequence, and m_data is stable while stalled.
